// File: rtl/nor_32bit.sv
// 32-bit bitwise NOR unit, r = ~(a | b), built from 32 one-bit slices.
// Define NOR_32BIT_REG_OUT_EN to add a one-cycle output register stage.

module nor_1bit (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a | b);
endmodule

module nor_32bit (
    output logic [31:0] r,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        out_valid,
    output logic        zero,
    output logic        ones
);
    localparam int unsigned W = 32;

    logic [W-1:0] w_r;
    logic         w_zero;
    logic         w_ones;

    // One independent slice per bit, so an unknown input bit only taints its own result bit
    for (genvar i = 0; i < W; i++) begin : g_slice
        nor_1bit u_slice (
            .a (a[i]),
            .b (b[i]),
            .y (w_r[i])
        );
    end

    assign w_zero = ~|w_r;
    assign w_ones = &w_r;

`ifdef NOR_32BIT_REG_OUT_EN
    logic [W-1:0] r_r;
    logic         r_zero;
    logic         r_ones;
    logic         r_valid;

    // Flags are registered alongside r from the same combinational value, keeping them consistent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r     <= '0;
            r_zero  <= 1'b1;
            r_ones  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_r     <= w_r;
            r_zero  <= w_zero;
            r_ones  <= w_ones;
            r_valid <= in_valid;
        end
    end

    assign r         = r_r;
    assign zero      = r_zero;
    assign ones      = r_ones;
    assign out_valid = r_valid;
`else
    logic w_unused;

    // clk and rst_n have no function in the combinational build
    assign w_unused  = clk ^ rst_n;

    assign r         = w_r;
    assign zero      = w_zero;
    assign ones      = w_ones;
    assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_nor_32bit.sv
// Self-checking bench for nor_32bit; scoreboard of expected results, works in both builds.
`timescale 1ns/1ps

module tb_nor_32bit;

    typedef struct {
        logic [31:0] r;
        logic        zero;
        logic        ones;
    } exp_t;

    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_valid;
    logic        zero;
    logic        ones;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    nor_32bit dut (
        .r         (r),
        .a         (a),
        .b         (b),
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .zero      (zero),
        .ones      (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one operand pair, then compare whatever the DUT presents after its latency
    task automatic step(input logic [31:0] ta, input logic [31:0] tb_, input logic tv);
        exp_t e;
        @(negedge clk);
        a        = ta;
        b        = tb_;
        in_valid = tv;
        if (tv) begin
            e.r    = ~(ta | tb_);
            e.zero = (e.r == 32'h0);
            e.ones = (e.r == 32'hFFFF_FFFF);
            exp_q.push_back(e);
        end
`ifdef NOR_32BIT_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        chk("out_valid", 32'(out_valid), 32'(tv));
        chk("flags_exclusive", 32'(zero & ones), 32'h0);
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("r", r, e.r);
                chk("zero", 32'(zero), 32'(e.zero));
                chk("ones", 32'(ones), 32'(e.ones));
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
`ifdef NOR_32BIT_REG_OUT_EN
        chk("rst_r", r, 32'h0);
        chk("rst_zero", 32'(zero), 32'h1);
        chk("rst_ones", 32'(ones), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
`else
        chk("rst_r", r, 32'hFFFF_FFFF);
        chk("rst_ones", 32'(ones), 32'h1);
        chk("rst_valid", 32'(out_valid), 32'h0);
`endif
        rst_n = 1'b1;

        step(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step(32'h0000_0000, 32'h0000_0000, 1'b1);
        step(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        step(32'h0000_00F0, 32'h0000_000F, 1'b1);
        step(32'h1234_5678, 32'h0F0F_0000, 1'b0);

        // Walking one on a with in_valid held high every cycle
        for (int i = 0; i < 32; i++) begin
            logic [31:0] one;
            one = 32'h1;
            step(one << i, 32'h0, 1'b1);
        end

        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i % 4 == 0) ? ~ra : 32'($urandom);
            step(ra, rb, 1'(i % 5 != 1));
        end

`ifdef NOR_32BIT_REG_OUT_EN
        // Reset between edges while a result is being presented
        step(32'h0000_0001, 32'h0000_0002, 1'b1);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_r", r, 32'h0);
        chk("midrst_zero", 32'(zero), 32'h1);
        chk("midrst_ones", 32'(ones), 32'h0);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h0, 32'h0, 1'b0);
        step(32'h0, 32'h0, 1'b0);
        step(32'hF000_000F, 32'h00FF_0000, 1'b1);
`else
        // rst_n has no effect in the combinational build
        step(32'h0000_0001, 32'h0000_0002, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_ignored_r", r, 32'hFFFF_FFFC);
        chk("rst_ignored_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b1;
        step(32'hF000_000F, 32'h00FF_0000, 1'b1);
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
